// File: rtl/alu_pipe_if.sv
//==============================================================================
// Module      : alu_pipe_if
// Description : Handshake/data bundle for the alu_pipe two-stage ALU.
//               master = operand producer / result consumer,
//               slave  = the ALU pipeline.
//   a, b        operands (WIDTH)          inst       4-bit opcode
//   in_valid    operand valid             in_ready   pipeline can accept
//   z           result (WIDTH)            flags      {ILLEGAL,ZERO,CARRY,OVF}
//   out_valid   result valid              out_ready  consumer can accept
//   sticky_clr  clear accumulated flags   sticky     accumulated flags
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       inst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] z;
    logic [3:0]       flags;
    logic             out_valid;
    logic             out_ready;
    logic             sticky_clr;
    logic [3:0]       sticky;

    modport master (
        output a, b, inst, in_valid, out_ready, sticky_clr,
        input  in_ready, z, flags, out_valid, sticky
    );

    modport slave (
        input  a, b, inst, in_valid, out_ready, sticky_clr,
        output in_ready, z, flags, out_valid, sticky
    );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
//==============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined ALU with valid/ready handshakes.
//               S1 registers operands + opcode, S2 registers result + flags.
//               Sticky flag accumulator ORs ILLEGAL/CARRY/OVF per transfer.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - alu_pipe_if.slave (operands, opcode, result, flags,
//                        both handshakes, sticky clear / sticky flags)
// Config      : `define ALU_DIVSTEP_EN enables the divide-step opcode 6;
//               otherwise opcode 6 returns zero with ILLEGAL set.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_pipe_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    // Stage 1: captured operands
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [3:0]       r_s1_inst;

    // Stage 2: result presented to the consumer
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_z;
    logic [3:0]       r_flags;
    logic [3:0]       r_sticky;

    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_out_xfer;
    logic [3:0]       w_xfer_flags;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_z;
    logic             w_carry;
    logic             w_ovf;
    logic             w_illegal;

    assign w_s1_adv     = !r_s2_valid || bus.out_ready;
    assign w_in_ready   = !r_s1_valid || w_s1_adv;
    assign w_out_xfer   = r_s2_valid && bus.out_ready;
    // ZERO never accumulates into STICKY
    assign w_xfer_flags = {r_flags[3], 1'b0, r_flags[1:0]};

    // Every arithmetic opcode is one adder pass X + Y + cin
    always_comb begin
        w_x     = '0;
        w_y     = '0;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (r_s1_inst)
            4'h0: begin w_x = r_s1_a; w_cin = 1'b1;                 end
            4'h1: begin w_x = r_s1_a; w_y = '1;                     end
            4'h2: begin w_x = r_s1_a; w_y = r_s1_b;                 end
            4'h3: begin w_x = r_s1_a; w_y = ~r_s1_b; w_cin = 1'b1;  end
            4'h4: begin
                if (!r_s1_a[MSB]) begin
                    w_x = r_s1_a;
                end else begin
                    w_y   = ~r_s1_a;
                    w_cin = 1'b1;
                end
            end
            4'h5: begin w_y = ~r_s1_a; w_cin = 1'b1;                end
            4'h7: begin w_y = ~r_s1_b; w_cin = 1'b1;                end
            default: w_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

`ifdef ALU_DIVSTEP_EN
    // Non-restoring divide step: subtract when signs agree, else add
    logic [WIDTH-1:0] w_div;
    assign w_div = (r_s1_a[MSB] == r_s1_b[MSB]) ? (r_s1_b - r_s1_a)
                                                : (r_s1_b + r_s1_a);
`endif

    always_comb begin
        w_z       = w_sum[WIDTH-1:0];
        w_carry   = w_sum[WIDTH];
        w_ovf     = (w_x[MSB] == w_y[MSB]) && (w_sum[MSB] != w_x[MSB]);
        w_illegal = 1'b0;
        if (!w_arith) begin
            w_carry = 1'b0;
            w_ovf   = 1'b0;
            case (r_s1_inst)
                4'h6: begin
`ifdef ALU_DIVSTEP_EN
                    w_z     = {w_div[WIDTH-2:0], 1'b0};
                    w_carry = w_div[MSB];
`else
                    w_z       = '0;
                    w_illegal = 1'b1;
`endif
                end
                4'h8:    w_z = r_s1_a & r_s1_b;
                4'h9:    w_z = r_s1_a | r_s1_b;
                4'hA:    w_z = r_s1_a ^ r_s1_b;
                4'hB:    w_z = ~r_s1_b;
                4'hC:    w_z = r_s1_a;
                4'hD:    w_z = ~r_s1_a;
                4'hE:    w_z = '0;
                default: w_z = '1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_inst  <= '0;
            r_s2_valid <= 1'b0;
            r_z        <= '0;
            r_flags    <= '0;
            r_sticky   <= '0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_a    <= bus.a;
                    r_s1_b    <= bus.b;
                    r_s1_inst <= bus.inst;
                end
            end
            // S2 only reloads when it is empty or being drained, so a
            // stalled result holds stable
            if (w_s1_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_z     <= w_z;
                    r_flags <= {w_illegal, (w_z == '0), w_carry, w_ovf};
                end
            end
            // Clear takes priority over accumulation but keeps the flags
            // of a transfer happening in the same cycle
            if (bus.sticky_clr) begin
                r_sticky <= w_out_xfer ? w_xfer_flags : 4'b0000;
            end else if (w_out_xfer) begin
                r_sticky <= r_sticky | w_xfer_flags;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.z         = r_z;
    assign bus.flags     = r_flags;
    assign bus.sticky    = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
//==============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH=32 main instance,
//               WIDTH=8 instance for narrow corner cases). A signed/unsigned
//               arithmetic model feeds an in-order scoreboard checked on
//               every falling edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus  ();
    alu_pipe_if #(.WIDTH(8))  bus8 ();

    alu_pipe #(.WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_pipe #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_checks = 0;
    int n_errors = 0;

    logic [35:0] q[$];          // expected {flags, z} in acceptance order
    logic [3:0]  exp_sticky;
    logic        prev_stall;
    logic [31:0] prev_z;
    logic [3:0]  prev_flags;
    logic        prev_s1_only;

    localparam longint MAXP = 64'sh7FFF_FFFF;
    localparam longint MINN = -64'sh8000_0000;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: true signed result, overflow = out of range
    function automatic logic [35:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  op);
        longint      sa, sb, r;
        logic [63:0] ua, ub;
        logic [31:0] z;
        logic        c, v, ill, arith;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        r = 0; z = '0; c = 1'b0; v = 1'b0; ill = 1'b0; arith = 1'b0;
        case (op)
            4'h0: begin r = sa + 1;  c = (a == 32'hFFFF_FFFF); arith = 1'b1; end
            4'h1: begin r = sa - 1;  c = (a != 0);             arith = 1'b1; end
            4'h2: begin r = sa + sb; c = ((ua + ub) >> 32) != 0; arith = 1'b1; end
            4'h3: begin r = sa - sb; c = (a >= b);             arith = 1'b1; end
            4'h4: begin r = (sa < 0) ? -sa : sa; c = 1'b0;     arith = 1'b1; end
            4'h5: begin r = -sa;     c = (a == 0);             arith = 1'b1; end
            4'h7: begin r = -sb;     c = (b == 0);             arith = 1'b1; end
            4'h6: begin
`ifdef ALU_DIVSTEP_EN
                logic [31:0] d;
                d = (a[31] == b[31]) ? (b - a) : (b + a);
                z = d << 1;
                c = d[31];
`else
                z   = '0;
                ill = 1'b1;
`endif
            end
            4'h8: z = a & b;
            4'h9: z = a | b;
            4'hA: z = a ^ b;
            4'hB: z = ~b;
            4'hC: z = a;
            4'hD: z = ~a;
            4'hE: z = 32'h0;
            default: z = 32'hFFFF_FFFF;
        endcase
        if (arith) begin
            z = r[31:0];
            v = (r > MAXP) || (r < MINN);
        end
        return {ill, (z == 32'h0), c, v, z};
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard / protocol monitor, samples on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_sticky   = 4'b0000;
            prev_stall   = 1'b0;
            prev_s1_only = 1'b0;
        end else begin
            int          occ;
            logic        xfer;
            logic [35:0] e;
            occ = q.size();
            check(bus.sticky == exp_sticky, "sticky", 64'(bus.sticky), 64'(exp_sticky));
            check(bus.in_ready == !(occ == 2 && !bus.out_ready), "in_ready",
                  64'(bus.in_ready), 64'(!(occ == 2 && !bus.out_ready)));
            if (prev_stall)
                check(bus.out_valid && bus.z == prev_z && bus.flags == prev_flags,
                      "stall_hold", {27'h0, bus.out_valid, bus.flags, bus.z},
                      {27'h0, 1'b1, prev_flags, prev_z});
            if (bus.out_valid)
                check(occ > 0, "spurious_out", 64'(bus.out_valid), 64'(0));
            if (occ > 0 && !bus.out_valid)
                check(!prev_s1_only, "latency", 64'(bus.out_valid), 64'(1));
            prev_s1_only = (occ > 0) && !bus.out_valid;
            xfer = 1'b0;
            e    = '0;
            if (bus.out_valid && bus.out_ready && occ > 0) begin
                e    = q.pop_front();
                xfer = 1'b1;
                check({bus.flags, bus.z} == e, "result", 64'({bus.flags, bus.z}), 64'(e));
            end
            if (bus.sticky_clr)
                exp_sticky = xfer ? (e[35:32] & 4'b1011) : 4'b0000;
            else if (xfer)
                exp_sticky = exp_sticky | (e[35:32] & 4'b1011);
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.inst));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_z     = bus.z;
            prev_flags = bus.flags;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.in_valid   = 1'b0;
            bus.out_ready  = 1'b1;
            bus.sticky_clr = 1'b0;
        end
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [35:0] exp,
                            input string name);
        @(posedge clk); #1;
        bus.a = a; bus.b = b; bus.inst = op;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check(!bus.out_valid, {name, "_early"}, 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        check(bus.out_valid && {bus.flags, bus.z} == exp, name,
              {27'h0, bus.out_valid, bus.flags, bus.z}, {27'h0, 1'b1, exp});
    endtask

    task automatic directed8(input logic [7:0] a, input logic [3:0] op,
                             input logic [11:0] exp, input string name);
        @(posedge clk); #1;
        bus8.a = a; bus8.inst = op; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(posedge clk); #1;
        check(bus8.out_valid && {bus8.flags, bus8.z} == exp, name,
              64'({bus8.out_valid, bus8.flags, bus8.z}), 64'({1'b1, exp}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        int         sent, cyc;
        logic       acc;
        logic [3:0] sticky_exp_lit;

        rst_n = 1'b0;
        bus.a = '0; bus.b = '0; bus.inst = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.sticky_clr = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.inst = '0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.sticky_clr = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check(!bus.out_valid && bus.z == 0 && bus.flags == 0 && bus.sticky == 0,
              "reset_state", {23'h0, bus.out_valid, bus.sticky, bus.flags, bus.z}, 64'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check(bus.in_ready, "ready_after_reset", 64'(bus.in_ready), 64'(1));

        // Pin the model with hand-computed values
        check(model(32'h7FFF_FFFF, 32'h1, 4'h2) == 36'h1_8000_0000, "model_add",
              64'(model(32'h7FFF_FFFF, 32'h1, 4'h2)), 64'h1_8000_0000);
        check(model(32'h5, 32'h5, 4'h3) == 36'h6_0000_0000, "model_sub",
              64'(model(32'h5, 32'h5, 4'h3)), 64'h6_0000_0000);
        check(model(32'h8000_0000, 32'h0, 4'h5) == 36'h1_8000_0000, "model_neg",
              64'(model(32'h8000_0000, 32'h0, 4'h5)), 64'h1_8000_0000);
        check(model(32'h8000_0000, 32'h0, 4'h4) == 36'h1_8000_0000, "model_abs",
              64'(model(32'h8000_0000, 32'h0, 4'h4)), 64'h1_8000_0000);

        // Directed literal cases on the 32-bit instance
        directed(32'h7FFF_FFFF, 32'h1, 4'h2, 36'h1_8000_0000, "add_ovf");
        idle(2);
        directed(32'h5, 32'h5, 4'h3, 36'h6_0000_0000, "sub_zero");
        idle(2);
        directed(32'h8000_0000, 32'h0, 4'h5, 36'h1_8000_0000, "neg_min");
        idle(2);
`ifdef ALU_DIVSTEP_EN
        directed(32'h3, 32'h10, 4'h6, 36'h0_0000_001A, "divstep");
        sticky_exp_lit = 4'b0011;
`else
        directed(32'h3, 32'h10, 4'h6, 36'hC_0000_0000, "illegal6");
        sticky_exp_lit = 4'b1011;
`endif
        idle(1);
        check(bus.sticky == sticky_exp_lit, "sticky_lit", 64'(bus.sticky), 64'(sticky_exp_lit));
        idle(3);
        check(bus.sticky == sticky_exp_lit, "sticky_hold", 64'(bus.sticky), 64'(sticky_exp_lit));
        @(posedge clk); #1 bus.sticky_clr = 1'b1;
        @(posedge clk); #1 bus.sticky_clr = 1'b0;
        check(bus.sticky == 4'b0000, "sticky_clear", 64'(bus.sticky), 64'(0));

        // Narrow instance corner cases
        directed8(8'hFF, 4'h0, 12'h6_00, "w8_inc_wrap");
        directed8(8'h80, 4'h4, 12'h1_80, "w8_abs_min");
        directed8(8'h00, 4'h5, 12'h6_00, "w8_neg_zero");
        idle(2);

        // Back-to-back 16 transactions with out_ready pattern 1,0,0,1
        pat  = 4'b1001;
        sent = 0;
        cyc  = 0;
        @(posedge clk); #1;
        bus.a = rnd_operand(); bus.b = rnd_operand(); bus.inst = 4'($urandom_range(0, 15));
        bus.in_valid = 1'b1; bus.out_ready = pat[0];
        while (sent < 16 && cyc < 200) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                bus.a = rnd_operand(); bus.b = rnd_operand();
                bus.inst = 4'($urandom_range(0, 15));
            end
            bus.out_ready = pat[cyc % 4];
            if (sent == 16) bus.in_valid = 1'b0;
        end
        check(sent == 16, "b2b_sent", 64'(sent), 64'(16));

        // Drain
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            idle(1);
            cyc++;
        end
        check(q.size() == 0, "b2b_drain", 64'(q.size()), 64'(0));

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            bus.a          = rnd_operand();
            bus.b          = rnd_operand();
            bus.inst       = 4'($urandom_range(0, 15));
            bus.in_valid   = ($urandom % 4) != 0;
            bus.out_ready  = ($urandom % 3) != 0;
            bus.sticky_clr = ($urandom % 16) == 0;
        end
        cyc = 0;
        idle(1);
        while (q.size() != 0 && cyc < 20) begin
            idle(1);
            cyc++;
        end
        check(q.size() == 0, "rand_drain", 64'(q.size()), 64'(0));

        // Reset with both stages full
        @(posedge clk); #1;
        bus.a = 32'h7FFF_FFFF; bus.b = 32'h1; bus.inst = 4'h2;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check(bus.out_valid && !bus.in_ready, "full_before_reset",
              64'({bus.out_valid, bus.in_ready}), 64'(2'b10));
        #1 rst_n = 1'b0;
        #1;
        check(!bus.out_valid && bus.z == 0 && bus.flags == 0 && bus.sticky == 0,
              "async_reset", {23'h0, bus.out_valid, bus.sticky, bus.flags, bus.z}, 64'h0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check(!bus.out_valid, "stale_after_reset", 64'(bus.out_valid), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (legal range 8..64).
REQ-002 Port: CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: A, B  input  WIDTH each  operands.
REQ-005 Port: INST  input  4  opcode.
REQ-006 Port: IN_VALID / IN_READY  input / output  1 each  input handshake; transfer when both high at an edge.
REQ-007 Port: Z  output  WIDTH  result.
REQ-008 Port: FLAGS  output  4  [0] OVF, [1] CARRY, [2] ZERO, [3] ILLEGAL.
REQ-009 Port: OUT_VALID / OUT_READY  output / input  1 each  output handshake; transfer when both high at an edge.
REQ-010 Port: STICKY_CLR  input  1  synchronous clear of STICKY.
REQ-011 Port: STICKY  output  4  accumulated FLAGS since last clear; bit 2 always 0.

Function
REQ-012 Opcodes SHALL be: 0 A+1, 1 A-1, 2 A+B, 3 A-B, 4 abs(A), 5 -A, 6 divstep (REQ-020), 7 -B, 8 A&B, 9 A|B, A A^B, B ~B, C A, D ~A, E all-zeros, F all-ones.
REQ-013 Arithmetic ops SHALL be computed as one WIDTH-bit sum X+Y+cin: 0 (A,0,1); 1 (A,all-ones,0); 2 (A,B,0); 3 (A,~B,1); 4 (A,0,0) if A[msb]=0 else (0,~A,1); 5 (0,~A,1); 7 (0,~B,1).
REQ-014 CARRY SHALL be the carry-out of that sum; OVF SHALL be 1 when X[msb]=Y[msb] and result[msb]!=X[msb].
REQ-015 Logic/pass/constant ops (8..F) SHALL produce OVF=0, CARRY=0.
REQ-016 ZERO SHALL be 1 exactly when Z is all zeros, for every opcode.
REQ-017 Pipeline SHALL have two register stages (S1 operands+opcode, S2 result+flags); a transaction accepted at edge k SHALL present Z/FLAGS with OUT_VALID=1 after edge k+1 when not stalled (latency 2 edges).
REQ-018 S1 SHALL advance when S2 is empty or OUT_READY=1; IN_READY SHALL equal (S1 empty) OR (S1 advancing); sustained throughput one transaction per cycle.
REQ-019 While OUT_VALID=1 and OUT_READY=0, Z, FLAGS and OUT_VALID SHALL hold stable and no transaction SHALL be lost or duplicated.
REQ-020 STICKY SHALL OR in FLAGS[3], FLAGS[1:0] on every output transfer; STICKY_CLR with simultaneous transfer SHALL leave exactly that transfer's flags.
REQ-021 Transactions SHALL emerge in acceptance order.

Reset
REQ-022 RESET_N low SHALL asynchronously clear S1/S2 valid, Z=0, FLAGS=0, STICKY=0; IN_READY SHALL be 1 once released.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight transactions; none SHALL appear after release.

Configuration
REQ-024 Macro ALU_DIVSTEP_EN defined: opcode 6 SHALL give Z=((A[msb]==B[msb]) ? B-A : B+A) << 1, CARRY = msb of pre-shift value, OVF=0, ILLEGAL=0.
REQ-025 ALU_DIVSTEP_EN undefined: opcode 6 SHALL give Z=0, ZERO=1, ILLEGAL=1, OVF=CARRY=0; ILLEGAL SHALL be 0 for all other opcodes in both builds.

Verification
REQ-026 WIDTH=32, INST=2, A=7FFFFFFF, B=1 -> Z=80000000, FLAGS=0001 two edges after acceptance.
REQ-027 WIDTH=32, INST=3, A=5, B=5 -> Z=0, FLAGS=0110; INST=5, A=80000000 -> Z=80000000, OVF=1, CARRY=0.
REQ-028 WIDTH=8, INST=0, A=FF -> Z=00, FLAGS=0110; INST=4, A=80 -> Z=80, OVF=1.
REQ-029 Back-to-back 16 random transactions, OUT_READY toggling 1-0-0-1 -> all 16 results match model, in order, stable while stalled, IN_READY low only when both stages full and OUT_READY=0.
REQ-030 INST=6, A=3, B=10 -> with ALU_DIVSTEP_EN Z=1A, FLAGS=0000; without Z=0, FLAGS=1100 and STICKY[3]=1 until STICKY_CLR.
REQ-031 RESET_N pulsed low with both stages full -> OUT_VALID=0, Z=0, FLAGS=0, STICKY=0 immediately; no stale output after release.
